adc_seq_ctrl: RTL and testbench

- Sequencer in front of the SPI word engine that talks to the external 16-bit ADC.
- After reset it pulses the ADC reset pin, waits for wake-up, writes a fixed table of configuration words, then issues periodic conversion commands.
- Conversions round-robin over the enabled channels; results go to the downstream datapath with channel tag, valid strobe and overrun flag.

---
 rtl/adc_seq_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: sequencer in front of the SPI word engine for an external
// 16-bit ADC. After reset it holds ADC_nRST low, waits for the ADC to wake,
// writes a fixed table of configuration words, then issues a conversion
// command on every sample tick, round-robin over the enabled channels.
//
// Ports:
//   clk_100M      system clock
//   n_rst         asynchronous active-low reset
//   ch_en[3:0]    channel enable mask, used when the next channel is picked
//   cfg_req       pulse: redo the reset / wake / config sequence
//   ovr_clr       clears the sticky overrun flag
//   spi_busy      SPI engine busy
//   spi_done      pulse: word transfer complete, spi_rx valid
//   spi_rx[15:0]  word received from the ADC
//   ADC_nRST      ADC reset pin, active low
//   spi_start     one-cycle transfer request
//   spi_tx[15:0]  word to transmit, stable from spi_start to spi_done
//   cfg_done      high while sampling
//   sample_valid  one-cycle result strobe
//   sample_ch     channel of the result
//   sample_data   conversion result
//   overrun       sticky: a sample tick was dropped
module adc_seq_ctrl #(
  parameter int          RST_CYC    = 100,
  parameter int          WAKE_CYC   = 1000,
  parameter int          NCFG       = 4,
  parameter logic [15:0] CFG0       = 16'h0000,
  parameter logic [15:0] CFG1       = 16'h0000,
  parameter logic [15:0] CFG2       = 16'h0000,
  parameter logic [15:0] CFG3       = 16'h0000,
  parameter int          SAMPLE_DIV = 500
) (
  input  logic        clk_100M,
  input  logic        n_rst,
  input  logic [3:0]  ch_en,
  input  logic        cfg_req,
  input  logic        ovr_clr,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [15:0] spi_rx,
  output logic        ADC_nRST,
  output logic        spi_start,
  output logic [15:0] spi_tx,
  output logic        cfg_done,
  output logic        sample_valid,
  output logic [1:0]  sample_ch,
  output logic [15:0] sample_data,
  output logic        overrun
);

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_WAKE,
    ST_CFG_ISSUE,
    ST_CFG_WAIT,
    ST_IDLE,
    ST_CONV_ISSUE,
    ST_CONV_WAIT
  } state_t;

  localparam logic [31:0] RST_LAST  = 32'(RST_CYC - 1);
  localparam logic [31:0] WAKE_LAST = 32'(WAKE_CYC - 1);
  localparam logic [31:0] TICK_LAST = 32'(SAMPLE_DIV - 1);
  localparam logic [1:0]  CFG_LAST  = 2'(NCFG - 1);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [31:0] r_tick_cnt;
  logic [1:0]  r_idx;
  logic [1:0]  r_ch;
  logic [1:0]  r_last_ch;
  logic        r_cfg_pend;
  logic        r_adc_nrst;
  logic        r_spi_start;
  logic [15:0] r_spi_tx;
  logic        r_cfg_done;
  logic        r_sample_valid;
  logic [1:0]  r_sample_ch;
  logic [15:0] r_sample_data;
  logic        r_overrun;

  logic        w_tick;
  logic        w_restart_req;

  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return CFG0;
      2'd1:    return CFG1;
      2'd2:    return CFG2;
      default: return CFG3;
    endcase
  endfunction

  // Lowest enabled channel strictly above last, wrapping 3->0. Offset 4
  // lands back on last itself, which covers the single-channel case.
  function automatic logic [1:0] next_ch(input logic [1:0] last, input logic [3:0] en);
    logic [1:0] c;
    logic       found;
    // NOTE: every local gets a value before any conditional use, so no
    // path leaves a variable holding a stale value (no latch in comb code).
    next_ch = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      c = last + 2'(k);
      if (!found && en[c]) begin
        next_ch = c;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_tick        = r_cfg_done && (r_tick_cnt == '0);
  // A request arriving in the same cycle as the final spi_done still counts.
  assign w_restart_req = r_cfg_pend | cfg_req;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_100M or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= ST_RST_HOLD;
      r_cnt          <= '0;
      r_tick_cnt     <= '0;
      r_idx          <= '0;
      r_ch           <= '0;
      r_last_ch      <= 2'd3;
      r_cfg_pend     <= 1'b0;
      r_adc_nrst     <= 1'b0;
      r_spi_start    <= 1'b0;
      r_spi_tx       <= '0;
      r_cfg_done     <= 1'b0;
      r_sample_valid <= 1'b0;
      r_sample_ch    <= '0;
      r_sample_data  <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_spi_start    <= 1'b0;
      r_sample_valid <= 1'b0;

      if (r_cfg_done) r_tick_cnt <= w_tick ? TICK_LAST : r_tick_cnt - 32'd1;

      // Set beats clear when both land in the same cycle.
      if (w_tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      else if (ovr_clr)                    r_overrun <= 1'b0;

      case (r_state)
        ST_RST_HOLD: begin
          if (r_cnt == RST_LAST) begin
            r_adc_nrst <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_WAKE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_WAKE: begin
          if (r_cnt == WAKE_LAST) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= ST_CFG_ISSUE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_CFG_ISSUE: begin
          if (!spi_busy) begin
            r_spi_tx    <= cfg_word(r_idx);
            r_spi_start <= 1'b1;
            r_state     <= ST_CFG_WAIT;
          end
        end
        ST_CFG_WAIT: begin
          if (spi_done) begin
            if (r_idx == CFG_LAST) begin
              r_cfg_done <= 1'b1;
              r_tick_cnt <= TICK_LAST;
              r_state    <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= ST_CFG_ISSUE;
            end
          end
        end
        ST_IDLE: begin
          if (cfg_req) begin
            r_cfg_done <= 1'b0;
            r_adc_nrst <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_RST_HOLD;
          end else if (w_tick && (ch_en != 4'd0)) begin
            r_ch    <= next_ch(r_last_ch, ch_en);
            r_state <= ST_CONV_ISSUE;
          end
        end
        ST_CONV_ISSUE: begin
          if (cfg_req) r_cfg_pend <= 1'b1;
          if (!spi_busy) begin
            r_spi_tx    <= {3'b000, 1'b1, r_ch, 10'd0};
            r_spi_start <= 1'b1;
            r_state     <= ST_CONV_WAIT;
          end
        end
        ST_CONV_WAIT: begin
          if (spi_done) begin
            r_sample_valid <= 1'b1;
            r_sample_data  <= spi_rx;
            r_sample_ch    <= r_ch;
            r_last_ch      <= r_ch;
            if (w_restart_req) begin
              r_cfg_pend <= 1'b0;
              r_cfg_done <= 1'b0;
              r_adc_nrst <= 1'b0;
              r_cnt      <= '0;
              r_state    <= ST_RST_HOLD;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (cfg_req) begin
            r_cfg_pend <= 1'b1;
          end
        end
        default: r_state <= ST_RST_HOLD;
      endcase
    end
  end

  assign ADC_nRST     = r_adc_nrst;
  assign spi_start    = r_spi_start;
  assign spi_tx       = r_spi_tx;
  assign cfg_done     = r_cfg_done;
  assign sample_valid = r_sample_valid;
  assign sample_ch    = r_sample_ch;
  assign sample_data  = r_sample_data;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Testbench for adc_seq_ctrl: SPI engine model plus scoreboard queues of
// expected transmit words and expected samples, popped as the DUT produces
// spi_start and sample_valid.
module tb_adc_seq_ctrl;

  localparam int SAMPLE_DIV = 50;

  logic        clk_100M = 1'b0;
  logic        n_rst    = 1'b0;
  logic [3:0]  ch_en    = 4'd0;
  logic        cfg_req  = 1'b0;
  logic        ovr_clr  = 1'b0;
  logic        spi_busy = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rx   = 16'h0000;
  logic        ADC_nRST;
  logic        spi_start;
  logic [15:0] spi_tx;
  logic        cfg_done;
  logic        sample_valid;
  logic [1:0]  sample_ch;
  logic [15:0] sample_data;
  logic        overrun;

  adc_seq_ctrl #(
    .RST_CYC(4), .WAKE_CYC(8), .NCFG(2),
    .CFG0(16'hA5A5), .CFG1(16'h5A5A), .CFG2(16'h0000), .CFG3(16'h0000),
    .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk_100M(clk_100M), .n_rst(n_rst), .ch_en(ch_en), .cfg_req(cfg_req),
    .ovr_clr(ovr_clr), .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx(spi_rx),
    .ADC_nRST(ADC_nRST), .spi_start(spi_start), .spi_tx(spi_tx), .cfg_done(cfg_done),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .overrun(overrun)
  );

  always #5 clk_100M = ~clk_100M;

  int cyc = 0;
  always @(posedge clk_100M) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // SPI engine model: busy from the cycle after spi_start, done after spi_delay
  // cycles. It is deliberately not reset, so a transfer cut by n_rst still
  // produces its stale spi_done.
  int          spi_delay = 20;
  int          spi_cnt   = 0;
  logic [15:0] rx_word   = 16'h1234;
  always @(posedge clk_100M) begin
    spi_done <= 1'b0;
    if (spi_busy) begin
      if (spi_cnt <= 1) begin
        spi_busy <= 1'b0;
        spi_done <= 1'b1;
        spi_rx   <= rx_word;
      end else begin
        spi_cnt <= spi_cnt - 1;
      end
    end else if (spi_start) begin
      spi_busy <= 1'b1;
      spi_cnt  <= spi_delay;
    end
  end

  // Scoreboard
  logic [15:0] exp_tx_q[$];
  logic [17:0] exp_smp_q[$];
  int          n_unexp_start = 0;
  int          n_unexp_smp   = 0;
  logic [15:0] tx_at_start   = 16'h0;
  bit          tx_pending    = 1'b0;

  always @(negedge clk_100M) begin
    logic [17:0] e;
    if (!n_rst) tx_pending = 1'b0;
    if (spi_start) begin
      if (exp_tx_q.size() > 0) check("spi_tx", spi_tx, exp_tx_q.pop_front());
      else n_unexp_start++;
      tx_at_start = spi_tx;
      tx_pending  = 1'b1;
    end
    if (spi_done && tx_pending) begin
      check("spi_tx_hold", spi_tx, tx_at_start);
      tx_pending = 1'b0;
    end
    if (sample_valid) begin
      if (exp_smp_q.size() > 0) begin
        e = exp_smp_q.pop_front();
        check("sample_ch", sample_ch, e[17:16]);
        check("sample_data", sample_data, e[15:0]);
      end else begin
        n_unexp_smp++;
      end
    end
  end

  // which: 0 = spi_start, 1 = sample_valid, 2 = cfg_done
  task automatic wait_for(input int which, input int max, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk_100M);
      if ((which == 0 && spi_start) || (which == 1 && sample_valid) ||
          (which == 2 && cfg_done)) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) @(negedge clk_100M);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_ADC_nRST"}, ADC_nRST, 0);
    check({pfx, "_spi_start"}, spi_start, 0);
    check({pfx, "_spi_tx"}, spi_tx, 0);
    check({pfx, "_cfg_done"}, cfg_done, 0);
    check({pfx, "_sample_valid"}, sample_valid, 0);
    check({pfx, "_sample_ch"}, sample_ch, 0);
    check({pfx, "_sample_data"}, sample_data, 0);
    check({pfx, "_overrun"}, overrun, 0);
  endtask

  initial begin
    bit seen;
    int n;
    int prev;
    int t0;

    // Power-up
    repeat (3) @(negedge clk_100M);
    check_reset_values("rst");
    exp_tx_q.push_back(16'hA5A5);
    exp_tx_q.push_back(16'h5A5A);
    ch_en = 4'b1011;
    n_rst = 1'b1;
    n = 0;
    while (!ADC_nRST && n < 50) begin
      @(negedge clk_100M);
      n++;
    end
    check("nrst_low_cycles", n, 4);
    n = 0;
    for (int k = 0; k < 400 && n < 2; k++) begin
      @(negedge clk_100M);
      if (spi_done) n++;
    end
    check("cfg_dones_seen", n, 2);
    check("cfg_done_at_last_done", cfg_done, 0);
    @(negedge clk_100M);
    check("cfg_done_rise", cfg_done, 1);

    // Round-robin over channels 0,1,3
    exp_tx_q.push_back(16'h1000); exp_smp_q.push_back({2'd0, 16'h1234});
    exp_tx_q.push_back(16'h1400); exp_smp_q.push_back({2'd1, 16'h1234});
    exp_tx_q.push_back(16'h1C00); exp_smp_q.push_back({2'd3, 16'h1234});
    exp_tx_q.push_back(16'h1000); exp_smp_q.push_back({2'd0, 16'h1234});
    prev = 0;
    for (int s = 0; s < 4; s++) begin
      wait_for(1, 150, seen);
      check("rr_sample_seen", seen, 1);
      if (s > 0) check("sample_period", cyc - prev, SAMPLE_DIV);
      prev = cyc;
    end
    ch_en = 4'd0;
    check("rr_no_overrun", overrun, 0);

    // No channels enabled for 5 ticks, then channel 2 only
    repeat (5 * SAMPLE_DIV) @(negedge clk_100M);
    check("disabled_no_start", n_unexp_start, 0);
    check("disabled_no_overrun", overrun, 0);
    exp_tx_q.push_back(16'h1800); exp_smp_q.push_back({2'd2, 16'h1234});
    ch_en = 4'b0100;
    wait_for(1, 150, seen);
    check("ch2_sample_seen", seen, 1);
    ch_en = 4'd0;

    // Overrun: transfers longer than the tick period
    spi_delay = 60;
    exp_tx_q.push_back(16'h1000); exp_smp_q.push_back({2'd0, 16'h1234});
    exp_tx_q.push_back(16'h1000); exp_smp_q.push_back({2'd0, 16'h1234});
    ch_en = 4'b0001;
    wait_for(0, 150, seen);
    check("ovr_start_seen", seen, 1);
    t0 = cyc - 2;
    goto_cyc(t0 + SAMPLE_DIV);
    check("ovr_before_drop", overrun, 0);
    goto_cyc(t0 + SAMPLE_DIV + 1);
    check("ovr_after_drop", overrun, 1);
    goto_cyc(t0 + 120);
    ovr_clr = 1'b1;
    goto_cyc(t0 + 121);
    ovr_clr = 1'b0;
    check("ovr_cleared", overrun, 0);
    goto_cyc(t0 + 3 * SAMPLE_DIV);
    ovr_clr = 1'b1;
    goto_cyc(t0 + 3 * SAMPLE_DIV + 1);
    ovr_clr = 1'b0;
    ch_en = 4'd0;
    check("ovr_set_wins", overrun, 1);
    wait_for(1, 150, seen);
    check("ovr_second_sample", seen, 1);
    ovr_clr = 1'b1;
    @(negedge clk_100M);
    ovr_clr = 1'b0;
    spi_delay = 20;

    // cfg_req while a conversion is in flight
    exp_tx_q.push_back(16'h1400); exp_smp_q.push_back({2'd1, 16'h1234});
    exp_tx_q.push_back(16'hA5A5);
    exp_tx_q.push_back(16'h5A5A);
    ch_en = 4'b0010;
    wait_for(0, 150, seen);
    check("req_start_seen", seen, 1);
    repeat (5) @(negedge clk_100M);
    cfg_req = 1'b1;
    @(negedge clk_100M);
    cfg_req = 1'b0;
    ch_en = 4'd0;
    wait_for(1, 100, seen);
    check("req_sample_seen", seen, 1);
    check("req_ADC_nRST", ADC_nRST, 0);
    check("req_cfg_done", cfg_done, 0);
    wait_for(2, 300, seen);
    check("req_reconfigured", seen, 1);
    check("req_tx_q_empty", exp_tx_q.size(), 0);

    // Reset in the middle of a conversion
    exp_tx_q.push_back(16'h1400);
    ch_en = 4'b0010;
    wait_for(0, 150, seen);
    check("mid_start_seen", seen, 1);
    repeat (3) @(negedge clk_100M);
    n_rst = 1'b0;
    #1;
    check_reset_values("mid");
    exp_tx_q.push_back(16'hA5A5);
    exp_tx_q.push_back(16'h5A5A);
    ch_en = 4'b1111;
    repeat (3) @(negedge clk_100M);
    n_rst = 1'b1;
    wait_for(2, 300, seen);
    check("mid_reconfigured", seen, 1);
    // last_ch is back at 3, so the first pick with all enabled is channel 0
    exp_tx_q.push_back(16'h1000); exp_smp_q.push_back({2'd0, 16'h1234});
    wait_for(1, 150, seen);
    check("post_rst_sample_seen", seen, 1);
    ch_en = 4'd0;
    repeat (20) @(negedge clk_100M);

    check("unexpected_starts", n_unexp_start, 0);
    check("unexpected_samples", n_unexp_smp, 0);
    check("tx_q_empty", exp_tx_q.size(), 0);
    check("smp_q_empty", exp_smp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
